instr_fetch: RTL and testbench

- Producer side of the instruction decode interface: fetches instruction words from instruction memory and presents opCode/functionCode to the control decoder.
- Consumes the decoder's pcSource and halt results to select the next PC.
- Sits between the instruction memory and the control/decode stage of the 16-bit CPU.
- Non-speculative: one fetch outstanding, and the next fetch starts only after the current instruction is accepted.

---
 rtl/instr_fetch.sv | 104 ++++++++++
 tb/tb_instr_fetch.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch: a single outstanding fetch from instruction memory, a held
// instruction for decode, and next-PC selection once decode accepts it.
module instr_fetch #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned RESET_PC   = 0,
  parameter int unsigned PC_STEP    = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  imemReq,
  output logic [ADDR_WIDTH-1:0] imemAddr,
  input  logic                  imemAck,
  input  logic [DATA_WIDTH-1:0] imemData,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [3:0]            opCode,
  output logic [3:0]            functionCode,
  output logic                  instrValid,
  input  logic                  instrReady,
  input  logic [1:0]            pcSource,
  input  logic                  halt,
  input  logic [ADDR_WIDTH-1:0] branchTarget,
  input  logic [ADDR_WIDTH-1:0] jumpTarget,
  input  logic [ADDR_WIDTH-1:0] regTarget,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic                  halted,
  output logic [15:0]           instrCount
);

  typedef enum logic [1:0] {
    START  = 2'd0,
    FETCH  = 2'd1,
    HOLD   = 2'd2,
    HALTED = 2'd3
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] target;
  logic [ADDR_WIDTH-1:0] next_pc;

  // Decode fields are plain slices of the held word.
  assign opCode       = instr[15:12];
  assign functionCode = instr[3:0];
  assign imemAddr     = pc;

  // Next-PC mux; with halfword steps, non-sequential targets are forced even.
  always_comb begin
    target = regTarget;
    case (pcSource)
      2'b01:   target = branchTarget;
      2'b10:   target = jumpTarget;
      default: target = regTarget;
    endcase
    if (PC_STEP == 2) target[0] = 1'b0;
    next_pc = (pcSource == 2'b00) ? (pc + ADDR_WIDTH'(PC_STEP)) : target;
  end

  // Fetch FSM with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= START;
      pc         <= ADDR_WIDTH'(RESET_PC);
      imemReq    <= 1'b0;
      instrValid <= 1'b0;
      instr      <= '0;
      halted     <= 1'b0;
      instrCount <= '0;
    end else begin
      case (state)
        START: begin
          imemReq <= 1'b1;
          state   <= FETCH;
        end
        FETCH: begin
          if (imemAck) begin
            instr      <= imemData;
            instrValid <= 1'b1;
            imemReq    <= 1'b0;
            state      <= HOLD;
          end
        end
        HOLD: begin
          if (instrReady) begin
            if (instrCount != 16'hFFFF) instrCount <= instrCount + 16'd1;
            instrValid <= 1'b0;
            if (halt) begin
              halted <= 1'b1;
              state  <= HALTED;
            end else begin
              pc      <= next_pc;
              imemReq <= 1'b1;
              state   <= FETCH;
            end
          end
        end
        default: begin
          imemReq    <= 1'b0;
          instrValid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: sequential fetch, stalls, redirects, wrap,
// halt and mid-transaction reset.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imemReq;
  logic [15:0] imemAddr;
  logic        imemAck;
  logic [15:0] imemData;
  logic [15:0] instr;
  logic [3:0]  opCode;
  logic [3:0]  functionCode;
  logic        instrValid;
  logic        instrReady;
  logic [1:0]  pcSource;
  logic        halt;
  logic [15:0] branchTarget;
  logic [15:0] jumpTarget;
  logic [15:0] regTarget;
  logic [15:0] pc;
  logic        halted;
  logic [15:0] instrCount;

  int total = 0;
  int bad   = 0;

  instr_fetch dut (
    .clk(clk), .rst_n(rst_n),
    .imemReq(imemReq), .imemAddr(imemAddr), .imemAck(imemAck), .imemData(imemData),
    .instr(instr), .opCode(opCode), .functionCode(functionCode),
    .instrValid(instrValid), .instrReady(instrReady),
    .pcSource(pcSource), .halt(halt),
    .branchTarget(branchTarget), .jumpTarget(jumpTarget), .regTarget(regTarget),
    .pc(pc), .halted(halted), .instrCount(instrCount)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Serve one fetch at addr after 'delay' idle cycles, then check the capture.
  task automatic do_fetch(input logic [15:0] addr, input logic [15:0] data,
                          input logic [3:0] exp_op, input logic [3:0] exp_fn,
                          input int delay);
    for (int i = 0; i < delay; i++) begin
      chk("wait_req", 16'(imemReq), 16'd1);
      chk("wait_addr", imemAddr, addr);
      chk("wait_valid", 16'(instrValid), 16'd0);
      @(negedge clk);
    end
    chk("req", 16'(imemReq), 16'd1);
    chk("addr", imemAddr, addr);
    imemAck  = 1'b1;
    imemData = data;
    @(negedge clk);
    imemAck  = 1'b0;
    imemData = 16'hDEAD;
    chk("valid", 16'(instrValid), 16'd1);
    chk("instr", instr, data);
    chk("opcode", 16'(opCode), 16'(exp_op));
    chk("func", 16'(functionCode), 16'(exp_fn));
    chk("req_off", 16'(imemReq), 16'd0);
  endtask

  // Hold the instruction for 'stall' cycles (with stray acks/garbage controls),
  // then accept it with the given redirect and halt.
  task automatic do_accept(input logic [1:0] src, input logic [15:0] tgt, input logic hlt,
                           input int stall, input logic [15:0] exp_cnt);
    logic [15:0] held;
    held = instr;
    for (int i = 0; i < stall; i++) begin
      imemAck      = 1'b1;
      imemData     = 16'hBEEF;
      pcSource     = 2'b11;
      halt         = 1'b1;
      regTarget    = 16'h0EEE;
      @(negedge clk);
      chk("stall_valid", 16'(instrValid), 16'd1);
      chk("stall_instr", instr, held);
      chk("stall_req", 16'(imemReq), 16'd0);
    end
    imemAck      = 1'b0;
    pcSource     = src;
    halt         = hlt;
    branchTarget = (src == 2'b01) ? tgt : 16'h1110;
    jumpTarget   = (src == 2'b10) ? tgt : 16'h2220;
    regTarget    = (src == 2'b11) ? tgt : 16'h3330;
    instrReady   = 1'b1;
    @(negedge clk);
    instrReady   = 1'b0;
    halt         = 1'b0;
    pcSource     = 2'b00;
    chk("acc_valid", 16'(instrValid), 16'd0);
    chk("acc_req", 16'(imemReq), 16'(!hlt));
    chk("acc_count", instrCount, exp_cnt);
    chk("acc_halted", 16'(halted), 16'(hlt));
  endtask

  initial begin
    rst_n = 1'b1; imemAck = 1'b0; imemData = 16'h0; instrReady = 1'b0;
    pcSource = 2'b00; halt = 1'b0;
    branchTarget = 16'h0; jumpTarget = 16'h0; regTarget = 16'h0;

    // Reset, with a stray ack held through release.
    #2 rst_n = 1'b0; imemAck = 1'b1; imemData = 16'h5555;
    #1;
    chk("rst_req", 16'(imemReq), 16'd0);
    chk("rst_valid", 16'(instrValid), 16'd0);
    chk("rst_instr", instr, 16'h0000);
    chk("rst_pc", pc, 16'h0000);
    chk("rst_halted", 16'(halted), 16'd0);
    chk("rst_count", instrCount, 16'h0000);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    imemAck = 1'b0;
    chk("start_valid", 16'(instrValid), 16'd0);

    // Sequential run, zero ack delay.
    do_fetch(16'h0000, 16'h0001, 4'h0, 4'h1, 0);
    do_accept(2'b00, 16'h0, 1'b0, 0, 16'd1);
    do_fetch(16'h0002, 16'h0002, 4'h0, 4'h2, 0);
    do_accept(2'b00, 16'h0, 1'b0, 0, 16'd2);
    do_fetch(16'h0004, 16'h8000, 4'h8, 4'h0, 0);
    do_accept(2'b00, 16'h0, 1'b0, 0, 16'd3);

    // Delayed ack and decode stall.
    do_fetch(16'h0006, 16'h1234, 4'h1, 4'h4, 3);
    do_accept(2'b01, 16'h0040, 1'b0, 2, 16'd4);

    // Redirects.
    do_fetch(16'h0040, 16'h2A05, 4'h2, 4'h5, 0);
    do_accept(2'b10, 16'h0101, 1'b0, 0, 16'd5);
    do_fetch(16'h0100, 16'h3B06, 4'h3, 4'h6, 1);
    do_accept(2'b11, 16'h0200, 1'b0, 0, 16'd6);
    do_fetch(16'h0200, 16'h4C07, 4'h4, 4'h7, 0);
    do_accept(2'b11, 16'hFFFE, 1'b0, 0, 16'd7);

    // Sequential wrap from 0xFFFE.
    do_fetch(16'hFFFE, 16'h5D08, 4'h5, 4'h8, 0);
    do_accept(2'b00, 16'h0, 1'b0, 0, 16'd8);

    // Halt: redirect inputs must not move pc.
    do_fetch(16'h0000, 16'hF00F, 4'hF, 4'hF, 0);
    do_accept(2'b01, 16'h0040, 1'b1, 1, 16'd9);
    for (int i = 0; i < 3; i++) begin
      imemAck = 1'b1; instrReady = 1'b1; imemData = 16'h7777;
      @(negedge clk);
      chk("halt_req", 16'(imemReq), 16'd0);
      chk("halt_valid", 16'(instrValid), 16'd0);
      chk("halt_flag", 16'(halted), 16'd1);
      chk("halt_pc", pc, 16'h0000);
      chk("halt_count", instrCount, 16'd9);
    end
    imemAck = 1'b0; instrReady = 1'b0;

    // Reset out of HALTED.
    rst_n = 1'b0;
    #1;
    chk("rst2_halted", 16'(halted), 16'd0);
    chk("rst2_count", instrCount, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst2_req", 16'(imemReq), 16'd1);
    chk("rst2_addr", imemAddr, 16'h0000);

    // Reset while a fetch is pending.
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rstf_req", 16'(imemReq), 16'd0);
    chk("rstf_pc", pc, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_fetch(16'h0000, 16'h0005, 4'h0, 4'h5, 0);
    do_accept(2'b00, 16'h0, 1'b0, 0, 16'd1);
    do_fetch(16'h0002, 16'h9006, 4'h9, 4'h6, 1);

    // Reset during HOLD.
    rst_n = 1'b0;
    #1;
    chk("rsth_valid", 16'(instrValid), 16'd0);
    chk("rsth_instr", instr, 16'h0000);
    chk("rsth_opcode", 16'(opCode), 16'd0);
    chk("rsth_count", instrCount, 16'd0);
    chk("rsth_pc", pc, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rsth_req", 16'(imemReq), 16'd1);
    chk("rsth_addr", imemAddr, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
